// File: rtl/round_sequencer_if.sv
// Signal bundle between the round sequencer and the rest of the quadrant game.
// Inputs to the sequencer: start/select pulses, frame tick, random value handshake,
// and the player's current quadrant. Outputs: random request, layer enables,
// counter clear, latched target, score/error counts, result pulses, game flags, step code.
// Modport master is the sequencer side; slave is the surrounding game logic.
interface round_sequencer_if;
    logic       start;
    logic       select;
    logic       frame_tick;
    logic       rand_ready;
    logic [2:0] rand_quad;
    logic [2:0] player_quad;
    logic       rand_req;
    logic       sprite_en;
    logic       answer_en;
    logic       clear_counter;
    logic [2:0] target_quad;
    logic [3:0] score;
    logic [1:0] errors;
    logic       hit;
    logic       miss;
    logic       win;
    logic       finish;
    logic [3:0] step;

    modport master (
        input  start, select, frame_tick, rand_ready, rand_quad, player_quad,
        output rand_req, sprite_en, answer_en, clear_counter, target_quad,
        output score, errors, hit, miss, win, finish, step
    );

    modport slave (
        output start, select, frame_tick, rand_ready, rand_quad, player_quad,
        input  rand_req, sprite_en, answer_en, clear_counter, target_quad,
        input  score, errors, hit, miss, win, finish, step
    );
endinterface

// File: rtl/round_sequencer.sv
// Game-round controller for the VGA quadrant game.
// Requests a random target quadrant, shows it for SHOW_FRAMES frames, then opens an
// answer window of ANSWER_FRAMES frames. A select compares the player's quadrant with
// the target; score and errors are tracked until ROUNDS_TO_WIN hits (win) or
// MAX_ERRORS misses (loss).
// Ports: clk, rst (synchronous, active-high), bus (round_sequencer_if.master).
// Every output is a flop; level outputs are decoded from the next state so they
// line up with the state they describe.
module round_sequencer #(
    parameter int unsigned SHOW_FRAMES   = 120,
    parameter int unsigned ANSWER_FRAMES = 300,
    parameter int unsigned ROUNDS_TO_WIN = 5,
    parameter int unsigned MAX_ERRORS    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    round_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StShow   = 3'd2,
        StAnswer = 3'd3,
        StCheck  = 3'd4,
        StWin    = 3'd5,
        StLose   = 3'd6
    } state_e;

    localparam logic [9:0] ShowLast   = 10'(SHOW_FRAMES - 1);
    localparam logic [9:0] AnswerLast = 10'(ANSWER_FRAMES - 1);
    localparam logic [3:0] WinScore   = 4'(ROUNDS_TO_WIN);
    localparam logic [1:0] MaxErrors  = 2'(MAX_ERRORS);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] answer_q, answer_d;
    logic [2:0] target_q, target_d;
    logic [3:0] score_q, score_d;
    logic [1:0] errors_q, errors_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
    logic       clr_q, clr_d;
    logic       rand_req_q, sprite_en_q, answer_en_q, win_q, finish_q;
    logic [3:0] score_inc;
    logic [1:0] errors_inc;

    // Saturating increments; the game normally ends before either limit is reached.
    assign score_inc  = (score_q == 4'hF) ? score_q : score_q + 4'd1;
    assign errors_inc = (errors_q == 2'h3) ? errors_q : errors_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        answer_d = answer_q;
        target_d = target_q;
        score_d  = score_q;
        errors_d = errors_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        clr_d    = 1'b0;
        case (state_q)
            StIdle, StWin, StLose: begin
                if (bus.start) begin
                    state_d  = StReq;
                    score_d  = 4'd0;
                    errors_d = 2'd0;
                    clr_d    = 1'b1;
                end
            end
            StReq: begin
                if (bus.rand_ready) begin
                    target_d = bus.rand_quad;
                    cnt_d    = 10'd0;
                    state_d  = StShow;
                end
            end
            StShow: begin
                if (bus.frame_tick) begin
                    if (cnt_q == ShowLast) begin
                        state_d = StAnswer;
                        cnt_d   = 10'd0;
                        clr_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            StAnswer: begin
                // Select beats a coincident final frame tick.
                if (bus.select) begin
                    answer_d = bus.player_quad;
                    state_d  = StCheck;
                end else if (bus.frame_tick) begin
                    if (cnt_q == AnswerLast) begin
                        miss_d   = 1'b1;
                        errors_d = errors_inc;
                        state_d  = (errors_inc == MaxErrors) ? StLose : StReq;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            StCheck: begin
                if (answer_q == target_q) begin
                    hit_d   = 1'b1;
                    score_d = score_inc;
                    state_d = (score_inc == WinScore) ? StWin : StReq;
                end else begin
                    miss_d   = 1'b1;
                    errors_d = errors_inc;
                    state_d  = (errors_inc == MaxErrors) ? StLose : StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 10'd0;
            answer_q    <= 3'd0;
            target_q    <= 3'd0;
            score_q     <= 4'd0;
            errors_q    <= 2'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            clr_q       <= 1'b0;
            rand_req_q  <= 1'b0;
            sprite_en_q <= 1'b0;
            answer_en_q <= 1'b0;
            win_q       <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            answer_q    <= answer_d;
            target_q    <= target_d;
            score_q     <= score_d;
            errors_q    <= errors_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            clr_q       <= clr_d;
            rand_req_q  <= (state_d == StReq);
            sprite_en_q <= (state_d == StShow);
            answer_en_q <= (state_d == StAnswer);
            win_q       <= (state_d == StWin);
            finish_q    <= (state_d == StWin) || (state_d == StLose);
        end
    end

    assign bus.rand_req      = rand_req_q;
    assign bus.sprite_en     = sprite_en_q;
    assign bus.answer_en     = answer_en_q;
    assign bus.clear_counter = clr_q;
    assign bus.target_quad   = target_q;
    assign bus.score         = score_q;
    assign bus.errors        = errors_q;
    assign bus.hit           = hit_q;
    assign bus.miss          = miss_q;
    assign bus.win           = win_q;
    assign bus.finish        = finish_q;
    assign bus.step          = {1'b0, state_q};

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer with SHOW_FRAMES=2, ANSWER_FRAMES=3, ROUNDS_TO_WIN=2,
// MAX_ERRORS=2: a directed vector table, hand-written corner sequences and a random
// run, all checked against expectations computed here.
module tb_round_sequencer;
    localparam int SHOW = 2;
    localparam int ANS  = 3;
    localparam int WINR = 2;
    localparam int MAXE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    round_sequencer_if bus ();

    round_sequencer #(
        .SHOW_FRAMES  (SHOW),
        .ANSWER_FRAMES(ANS),
        .ROUNDS_TO_WIN(WINR),
        .MAX_ERRORS   (MAXE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: step code, frames still to go, scores, pending pulses.
    int m_step, m_left, m_ans, m_tq, m_score, m_err;
    bit m_hit, m_miss, m_clr;

    task automatic model_update(input bit r, input bit s, input bit sel, input bit tk,
                                input bit rdy, input int rq, input int pq);
        m_hit = 0; m_miss = 0; m_clr = 0;
        if (r) begin
            m_step = 0; m_left = 0; m_ans = 0; m_tq = 0; m_score = 0; m_err = 0;
            return;
        end
        if (m_step == 0 || m_step == 5 || m_step == 6) begin
            if (s) begin m_step = 1; m_score = 0; m_err = 0; m_clr = 1; end
        end else if (m_step == 1) begin
            if (rdy) begin m_tq = rq; m_step = 2; m_left = SHOW; end
        end else if (m_step == 2) begin
            if (tk) begin
                m_left--;
                if (m_left == 0) begin m_step = 3; m_left = ANS; m_clr = 1; end
            end
        end else if (m_step == 3) begin
            if (sel) begin
                m_ans = pq; m_step = 4;
            end else if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_miss = 1;
                    if (m_err < 3) m_err++;
                    m_step = (m_err == MAXE) ? 6 : 1;
                end
            end
        end else if (m_step == 4) begin
            if (m_ans == m_tq) begin
                m_hit = 1;
                if (m_score < 15) m_score++;
                m_step = (m_score == WINR) ? 5 : 1;
            end else begin
                m_miss = 1;
                if (m_err < 3) m_err++;
                m_step = (m_err == MAXE) ? 6 : 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] act_flags();
        return {bus.rand_req, bus.sprite_en, bus.answer_en, bus.win, bus.finish,
                bus.clear_counter, bus.hit, bus.miss};
    endfunction

    task automatic check_model();
        logic [7:0] ef;
        ef = {m_step == 1, m_step == 2, m_step == 3, m_step == 5, m_step >= 5,
              m_clr, m_hit, m_miss};
        chk("step", int'(bus.step), m_step);
        chk("score", int'(bus.score), m_score);
        chk("errors", int'(bus.errors), m_err);
        chk("target_quad", int'(bus.target_quad), m_tq);
        chk("flags", int'(act_flags()), int'(ef));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
    task automatic apply(input bit r, input bit s, input bit sel, input bit tk,
                         input bit rdy, input int rq, input int pq);
        rst = r; bus.start = s; bus.select = sel; bus.frame_tick = tk;
        bus.rand_ready = rdy; bus.rand_quad = 3'(rq); bus.player_quad = 3'(pq);
        @(posedge clk);
        model_update(r, s, sel, tk, rdy, rq, pq);
        #1;
    endtask

    task automatic cyc(input bit r, input bit s, input bit sel, input bit tk,
                       input bit rdy, input int rq, input int pq);
        apply(r, s, sel, tk, rdy, rq, pq);
        check_model();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    typedef struct {
        bit         r, s, sel, tk, rdy;
        int         rq, pq;
        int         step, score, errors, tq;
        logic [7:0] flags; // rand_req sprite answer win finish clr hit miss
    } vec_t;

    vec_t tbl[15];

    initial begin
        bus.start = 0; bus.select = 0; bus.frame_tick = 0; bus.rand_ready = 0;
        bus.rand_quad = 0; bus.player_quad = 0;
        m_step = 0; m_left = 0; m_ans = 0; m_tq = 0; m_score = 0; m_err = 0;
        m_hit = 0; m_miss = 0; m_clr = 0;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000_000};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000_000};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000_000};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000_000};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b10000_100};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b10000_000};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b10000_000};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b10000_000};
        tbl[8]  = '{0, 0, 0, 0, 1, 3, 0, 2, 0, 0, 3, 8'b01000_000};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3, 8'b01000_000};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 3, 8'b00100_100};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3, 8'b00100_000};
        tbl[12] = '{0, 0, 1, 0, 0, 0, 3, 4, 0, 0, 3, 8'b00000_000};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 8'b10000_010};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 8'b10000_000};

        // Directed table: reset, idle select, one correct round.
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].sel, tbl[i].tk, tbl[i].rdy, tbl[i].rq, tbl[i].pq);
            chk($sformatf("tbl%0d.step", i), int'(bus.step), tbl[i].step);
            chk($sformatf("tbl%0d.score", i), int'(bus.score), tbl[i].score);
            chk($sformatf("tbl%0d.errors", i), int'(bus.errors), tbl[i].errors);
            chk($sformatf("tbl%0d.target", i), int'(bus.target_quad), tbl[i].tq);
            chk($sformatf("tbl%0d.flags", i), int'(act_flags()), int'(tbl[i].flags));
        end

        // Win: two correct rounds, then restart.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        tick(); tick();
        cyc(0, 0, 1, 0, 0, 0, 3);
        idle();
        cyc(0, 0, 0, 0, 1, 1, 0);
        tick(); tick();
        cyc(0, 0, 1, 0, 0, 0, 1);
        idle();
        chk("win.step", int'(bus.step), 5);
        chk("win.win", int'(bus.win), 1);
        chk("win.finish", int'(bus.finish), 1);
        idle();
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("restart.step", int'(bus.step), 1);
        chk("restart.score", int'(bus.score), 0);
        chk("restart.win", int'(bus.win), 0);

        // Loss: wrong answer, then a timeout.
        cyc(0, 0, 0, 0, 1, 2, 0);
        tick(); tick();
        cyc(0, 0, 1, 0, 0, 0, 1);
        idle();
        chk("wrong.errors", int'(bus.errors), 1);
        chk("wrong.miss", int'(bus.miss), 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        tick(); tick();
        tick(); tick(); tick();
        chk("timeout.miss", int'(bus.miss), 1);
        chk("timeout.errors", int'(bus.errors), 2);
        chk("lose.step", int'(bus.step), 6);
        chk("lose.finish", int'(bus.finish), 1);
        chk("lose.win", int'(bus.win), 0);

        // Select together with the final answer tick: no timeout.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5, 0);
        tick(); tick();
        tick(); tick();
        cyc(0, 0, 1, 1, 0, 0, 5);
        chk("simul.step", int'(bus.step), 4);
        idle();
        chk("simul.hit", int'(bus.hit), 1);
        chk("simul.miss", int'(bus.miss), 0);
        chk("simul.errors", int'(bus.errors), 0);

        // Reset in the middle of SHOW.
        cyc(0, 0, 0, 0, 1, 1, 0);
        tick();
        chk("midshow.score", int'(bus.score), 1);
        chk("midshow.step", int'(bus.step), 2);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("midrst.step", int'(bus.step), 0);
        chk("midrst.score", int'(bus.score), 0);
        chk("midrst.sprite", int'(bus.sprite_en), 0);
        chk("midrst.req", int'(bus.rand_req), 0);

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 200) == 0, ($urandom % 15) == 0, ($urandom % 6) == 0,
                ($urandom % 3) == 0, ($urandom % 4) == 0,
                int'($urandom % 2), int'($urandom % 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
